// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// master drives the request side, slave is the arithmetic block.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             Cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             Cout;
   logic             ovf;

   modport master (
      output start, sub, a, b, Cin,
      input  busy, done, sum, Cout, ovf
   );

   modport slave (
      input  start, sub, a, b, Cin,
      output busy, done, sum, Cout, ovf
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one shared 1-bit full adder,
// LSB first, one bit per clock, result registered on completion.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   serial_add_ctrl_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, res_reg, sum_reg;
   logic [CW-1:0]    cnt_reg;
   logic             carry_reg, cout_reg, ovf_reg;
   logic             fa_sum, fa_cout;
   logic             accept, last;

   assign accept = (state_reg != RUN) && bus.start;
   assign last   = (cnt_reg == CW'(WIDTH - 1));

   fullAdder u_fa (
      .i1   (a_reg[0]),
      .i2   (b_reg[0]),
      .Cin  (carry_reg),
      .Cout (fa_cout),
      .sum  (fa_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE: state_next = bus.start ? RUN : IDLE;
         RUN:        if (last) state_next = DONE;
         default:    state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_reg == RUN);
      bus.done = (state_reg == DONE);
      bus.sum  = sum_reg;
      bus.Cout = cout_reg;
      bus.ovf  = ovf_reg;
   end

   // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         sum_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else if (accept) begin
         a_reg     <= bus.a;
         b_reg     <= bus.sub ? ~bus.b : bus.b;
         carry_reg <= bus.sub ? 1'b1 : bus.Cin;
         cnt_reg   <= '0;
      end else if (state_reg == RUN) begin
         res_reg   <= {fa_sum, res_reg[WIDTH-1:1]};
         carry_reg <= fa_cout;
         a_reg     <= a_reg >> 1;
         b_reg     <= b_reg >> 1;
         cnt_reg   <= cnt_reg + 1'b1;
         // On the MSB step carry_reg is the carry into the MSB.
         if (last) begin
            sum_reg  <= {fa_sum, res_reg[WIDTH-1:1]};
            cout_reg <= fa_cout;
            ovf_reg  <= carry_reg ^ fa_cout;
         end
      end
   end
endmodule

module fullAdder (
   input  logic i1,
   input  logic i2,
   input  logic Cin,
   output logic Cout,
   output logic sum
);
   assign sum  = i1 ^ i2 ^ Cin;
   assign Cout = (i1 & i2) | (i1 & Cin) | (i2 & Cin);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): results are predicted
// at issue time and compared whenever done pulses.
module tb_serial_add_ctrl;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb_q[$];
   exp_t cur_exp;
   logic [W-1:0] prev_sum;

   serial_add_ctrl_if #(.WIDTH(W)) bus ();

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin);
      logic [W-1:0] bb;
      logic [W:0]   full;
      exp_t         e;
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      return e;
   endfunction

   // Drive a request in the current cycle and record the prediction.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.sub   = sub;
      bus.Cin   = cin;
      cur_exp   = model(a, b, sub, cin);
      sb_q.push_back(cur_exp);
      $display("issue a=%02h b=%02h sub=%0b cin=%0b -> exp sum=%02h cout=%0b ovf=%0b",
               a, b, sub, cin, cur_exp.sum, cur_exp.cout, cur_exp.ovf);
   endtask

   // Walk cycles E+1..E+W+1; poke>0 pulses a stray start in that RUN cycle.
   task automatic expect_run(input int poke);
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.a     = W'($urandom);
         bus.b     = W'($urandom);
         bus.sub   = 1'($urandom);
         bus.Cin   = 1'($urandom);
         if (i == poke) begin
            bus.start = 1'b1;
            bus.a     = 8'h01;
            bus.b     = 8'h01;
         end
         if (i == 1) check("sum_hold", {24'd0, bus.sum}, {24'd0, prev_sum});
         check($sformatf("busy_run%0d", i), {31'd0, bus.busy}, 32'd1);
         if (i == W) check("done_early", {31'd0, bus.done}, 32'd0);
      end
      @(negedge clk);
      bus.start = 1'b0;
      check("done_pulse", {31'd0, bus.done}, 32'd1);
      check("busy_in_done", {31'd0, bus.busy}, 32'd0);
      prev_sum = cur_exp.sum;
   endtask

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb_q.size() == 0) begin
            check("spurious_done", {31'd0, bus.done}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("done sum=%02h cout=%0b ovf=%0b", bus.sum, bus.Cout, bus.ovf);
            check("sum",  {24'd0, bus.sum},  {24'd0, e.sum});
            check("cout", {31'd0, bus.Cout}, {31'd0, e.cout});
            check("ovf",  {31'd0, bus.ovf},  {31'd0, e.ovf});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic saw_done;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.Cin   = 1'b0;
      prev_sum  = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_sum",  {24'd0, bus.sum},  32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(8'h5A, 8'h3C, 1'b0, 1'b0); expect_run(0); @(negedge clk);
      issue(8'hFF, 8'h00, 1'b0, 1'b1); expect_run(0); @(negedge clk);
      issue(8'hFF, 8'h01, 1'b0, 1'b0); expect_run(0); @(negedge clk);
      issue(8'h10, 8'h20, 1'b1, 1'b0); expect_run(0); @(negedge clk);
      issue(8'h80, 8'h01, 1'b1, 1'b0); expect_run(0); @(negedge clk);
      // Cin must be ignored for subtraction.
      issue(8'h80, 8'h01, 1'b1, 1'b1); expect_run(0); @(negedge clk);

      // Stray start three cycles into a running operation.
      issue(8'h5A, 8'h3C, 1'b0, 1'b0); expect_run(3); @(negedge clk);

      // Abort after three RUN cycles.
      issue(8'h11, 8'h22, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      check("abort_sum",  {24'd0, bus.sum},  32'd0);
      check("abort_cout", {31'd0, bus.Cout}, 32'd0);
      check("abort_ovf",  {31'd0, bus.ovf},  32'd0);
      prev_sum = '0;
      saw_done = 1'b0;
      repeat (W + 2) begin
         @(negedge clk);
         saw_done = saw_done | bus.done;
      end
      check("abort_no_done", {31'd0, saw_done}, 32'd0);

      issue(8'h7F, 8'h01, 1'b0, 1'b0); expect_run(0); @(negedge clk);

      // Back-to-back: new request issued in the DONE cycle.
      issue(8'h5A, 8'h3C, 1'b0, 1'b0); expect_run(0);
      issue(8'h03, 8'h04, 1'b0, 1'b0); expect_run(0);
      issue(8'hC3, 8'h5A, 1'b1, 1'b0); expect_run(0);
      @(negedge clk);
      check("idle_after", {31'd0, bus.busy | bus.done}, 32'd0);

      repeat (3) @(negedge clk);
      check("scoreboard_drain", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
